// File: rtl/mac_dot_sequencer_if.sv
// Handshake/bus bundle for mac_dot_sequencer.
//   Job control : start, len[3:0], abort          (host -> sequencer)
//   Operands    : in_valid, a[3:0], b[3:0]        (host -> sequencer)
//                 in_ready                        (sequencer -> host)
//   Result      : out_valid, result[11:0]         (sequencer -> consumer)
//                 out_ready                       (consumer -> sequencer)
//   Status      : busy, term_cnt[3:0]             (sequencer -> host)
// master = feeder/consumer side, slave = the sequencer.
interface mac_dot_sequencer_if;
  logic        start;
  logic [3:0]  len;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] result;
  logic        busy;
  logic [3:0]  term_cnt;

  modport master (
    output start, len, abort, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy, term_cnt
  );

  modport slave (
    input  start, len, abort, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy, term_cnt
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: sequences a 4x4 multiply-accumulate dot product of
// 1..16 operand pairs into a 12-bit accumulator.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : mac_dot_sequencer_if.slave (job control, operand stream,
//          result stream, status)
// The product source is a single vedic_4x4 multiplier. All outputs come
// straight from registers; no input reaches an output combinationally.

// Vedic (Urdhva-Tiryagbhyam) 4x4 unsigned multiplier built from four 2x2
// partial products.
//   i_a, i_b : 4-bit unsigned operands
//   o_p      : 8-bit product
module vedic_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    logic [3:0] q;
    q[0] = x[0] & y[0];
    q[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    q[2] = (x[1] & y[1]) ^ c;
    q[3] = (x[1] & y[1]) & c;
    return q;
  endfunction

  logic [3:0] w_ll;
  logic [3:0] w_hl;
  logic [3:0] w_lh;
  logic [3:0] w_hh;
  logic [4:0] w_mid;

  assign w_ll  = mul2(i_a[1:0], i_b[1:0]);
  assign w_hl  = mul2(i_a[3:2], i_b[1:0]);
  assign w_lh  = mul2(i_a[1:0], i_b[3:2]);
  assign w_hh  = mul2(i_a[3:2], i_b[3:2]);
  assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
  assign o_p   = {4'b0000, w_ll} + {1'b0, w_mid, 2'b00} + {w_hh, 4'b0000};
endmodule

module mac_dot_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  mac_dot_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_len;
  logic [11:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic [7:0]  w_prod;

  vedic_4x4 u_mul (
    .i_a (bus.a),
    .i_b (bus.b),
    .o_p (w_prod)
  );

  // 16 x 225 = 3600 < 4096, so the accumulator can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.abort) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_len      <= bus.len;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          // r_in_ready is high throughout RUN, so in_valid alone marks a beat.
          if (bus.in_valid && r_in_ready) begin
            r_acc <= r_acc + {4'b0000, w_prod};
            r_cnt <= r_cnt + 4'd1;
            // Count is taken before the increment: equality marks the last beat.
            if (r_cnt == r_len) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.result    = r_acc;
  assign bus.term_cnt  = r_cnt;
endmodule
